// File: rtl/ssi_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssi_scan_ctrl
// Brief    : Periodic scheduler time-sharing one SSI reader among NCH encoders.
// Revision : 1.0
// ============================================================================
module ssi_scan_ctrl #(
  parameter int NCH     = 4,
  parameter int CW      = 2,
  parameter int DIM     = 32,
  parameter int PERIOD  = 50000,
  parameter int GAP     = 1000,
  parameter int TIMEOUT = 60000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           ovr_clr,
  output logic [CW-1:0]  ssi_sel,
  output logic           ssi_rd,
  input  logic           ssi_rdy,
  input  logic [DIM-1:0] ssi_data,
  output logic           ch_valid,
  output logic [CW-1:0]  ch_idx,
  output logic [DIM-1:0] ch_data,
  output logic           ch_err,
  output logic           scan_done,
  output logic           busy,
  output logic           ovr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [PW-1:0] C_CNT_LAST = PW'(PERIOD - 1);
  // Timeout is decided one cycle early so the registered error strobe lands
  // in the cycle the wait counter would read TIMEOUT-1.
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 2);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP);
  localparam logic [CW-1:0] C_CH_LAST  = CW'(NCH - 1);

  logic [1:0]     r_state;
  logic [PW-1:0]  r_cnt;
  logic [TW-1:0]  r_tmo;
  logic [GW-1:0]  r_gap;
  logic [CW-1:0]  r_ch;
  logic [DIM-1:0] r_data;
  logic           r_rdy_q;
  logic           r_valid;
  logic           r_err;
  logic           r_done;
  logic           r_ovr;
  logic           w_tick;
  logic           w_rdy_rise;

  assign w_tick     = (r_cnt == C_CNT_LAST);
  assign w_rdy_rise = ssi_rdy & ~r_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_ch    <= '0;
      r_data  <= '0;
      r_rdy_q <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_rdy_q <= ssi_rdy;
      r_valid <= 1'b0;
      r_done  <= 1'b0;

      if (!enable || w_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + PW'(1);

      if (w_tick && (r_state != S_IDLE)) r_ovr <= 1'b1;
      else if (ovr_clr)                  r_ovr <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_tick && enable) begin
            r_ch    <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + TW'(1);
          if (w_rdy_rise) begin
            r_valid <= 1'b1;
            r_err   <= 1'b0;
            r_data  <= ssi_data;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (r_tmo == C_TMO_LAST) begin
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_data  <= '0;
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // First GAP cycle carries the result strobe, then GAP idle cycles.
          if (r_gap == C_GAP_LAST) begin
            if ((r_ch == C_CH_LAST) || !enable) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ch    <= r_ch + CW'(1);
              r_state <= S_ISSUE;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ssi_sel   = r_ch;
  assign ssi_rd    = (r_state == S_ISSUE);
  assign ch_valid  = r_valid;
  assign ch_idx    = r_ch;
  assign ch_data   = r_data;
  assign ch_err    = r_err;
  assign scan_done = r_done;
  assign busy      = (r_state != S_IDLE);
  assign ovr       = r_ovr;

endmodule
`default_nettype wire
